// File: rtl/sat_accumulator_if.sv
// sat_accumulator_if: sample-in / result-out handshake bundle for sat_accumulator
interface sat_accumulator_if #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              out_ovf;
  logic              ovf_sticky;
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, ovf_sticky
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf, ovf_sticky
  );
endinterface

// File: rtl/sat_accumulator.sv
// sat_accumulator: BURST-sample accumulator with overflow flags; define SAT_ACCUM_SATURATE_EN to clamp instead of wrap
module sat_accumulator #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 8,
  parameter int BURST  = 4
) (
  input logic              clk,
  input logic              rst_n,
  input logic              clear,
  sat_accumulator_if.slave bus
);
  localparam int CW = $clog2(BURST + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;
  state_t           state, state_d;
  logic [ACC_W-1:0] acc, acc_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             ovf, ovf_d, sticky, sticky_d;
  logic [ACC_W:0]   sum;
  logic             accept, deliver;
  assign bus.in_ready   = (state != HOLD) && !clear;
  assign bus.out_valid  = state == HOLD;
  assign bus.out_data   = acc;
  assign bus.out_ovf    = ovf;
  assign bus.ovf_sticky = sticky;
  assign accept  = bus.in_valid && bus.in_ready;
  assign deliver = bus.out_valid && bus.out_ready;
  assign sum     = {1'b0, acc} + (ACC_W + 1)'(bus.in_data);
  always_comb begin
    state_d  = state;
    acc_d    = acc;
    cnt_d    = cnt;
    ovf_d    = ovf;
    sticky_d = sticky;
    if (clear) begin
      state_d  = IDLE;
      acc_d    = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      sticky_d = 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          acc_d   = ACC_W'(bus.in_data);
          cnt_d   = CW'(1);
          ovf_d   = 1'b0;
          state_d = (BURST == 1) ? HOLD : ACCUM;
        end
        ACCUM: if (accept) begin
          cnt_d    = cnt + 1'b1;
`ifdef SAT_ACCUM_SATURATE_EN
          acc_d    = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
          acc_d    = sum[ACC_W-1:0];
`endif
          ovf_d    = ovf | sum[ACC_W];
          sticky_d = sticky | sum[ACC_W];
          state_d  = (cnt_d == CW'(BURST)) ? HOLD : ACCUM;
        end
        HOLD: if (deliver) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      sticky <= 1'b0;
    end else begin
      state  <= state_d;
      acc    <= acc_d;
      cnt    <= cnt_d;
      ovf    <= ovf_d;
      sticky <= sticky_d;
    end
  end
endmodule

// File: tb/tb_sat_accumulator.sv
// tb_sat_accumulator: directed and randomized checks of sat_accumulator against a burst-level arithmetic model
module tb_sat_accumulator;
  localparam int DATA_W = 4, ACC_W = 5, BURST = 4, MAXV = (1 << ACC_W) - 1;
`ifdef SAT_ACCUM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  int n_chk = 0, n_pass = 0;
  int m_acc = 0, m_cnt = 0;
  bit m_hold = 0, m_ovf = 0, m_sticky = 0;
  sat_accumulator_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();
  sat_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_W), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
  endtask
  // Model: running sum in plain integers, clamped or wrapped when it exceeds full scale
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      m_acc = 0; m_cnt = 0; m_hold = 0; m_ovf = 0; m_sticky = 0;
    end else if (m_hold) begin
      if (bus.out_ready) begin m_hold = 0; m_acc = 0; m_cnt = 0; end
    end else if (bus.in_valid) begin
      if (m_cnt == 0) m_ovf = 0;
      m_acc = m_acc + int'(bus.in_data);
      if (m_acc > MAXV) begin
        m_ovf = 1; m_sticky = 1;
        m_acc = SAT ? MAXV : m_acc - (MAXV + 1);
      end
      m_cnt++;
      m_hold = (m_cnt == BURST);
    end
  end
  always @(negedge clk) begin
    chk("out_valid", bus.out_valid, m_hold);
    chk("out_data", bus.out_data, m_acc);
    chk("out_ovf", bus.out_ovf, m_ovf);
    chk("ovf_sticky", bus.ovf_sticky, m_sticky);
    chk("in_ready", bus.in_ready, !m_hold && !clear);
  end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic send(input int v);
    int g = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = DATA_W'(v);
    #1;
    while (!bus.in_ready && g < 40) begin step(); #1; g++; end
    chk("send_ready", bus.in_ready, 1);
    step();
  endtask
  task automatic burst(input int a, input int b, input int c, input int d);
    send(a); send(b); send(c); send(d);
    bus.in_valid = 1'b0;
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    repeat (3) step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_sticky", bus.ovf_sticky, 0);
    rst_n = 1'b1;
    step();
    send(1); send(2);
    bus.in_valid = 1'b0;
    chk("partial_sum", bus.out_data, 3);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_data", bus.out_data, 0);
    chk("async_rst_valid", bus.out_valid, 0);
    step();
    rst_n = 1'b1;
    burst(1, 1, 1, 1);
    chk("fresh_1111", bus.out_data, 4);
    step();
    burst(3, 5, 7, 9);
    chk("b3579_valid", bus.out_valid, 1);
    chk("b3579_data", bus.out_data, 24);
    chk("b3579_ovf", bus.out_ovf, 0);
    chk("b3579_ready_low", bus.in_ready, 0);
    step();
    chk("b3579_ready_back", bus.in_ready, 1);
    burst(15, 15, 15, 1);
    chk("ovf_data", bus.out_data, SAT ? 31 : 14);
    chk("ovf_flag", bus.out_ovf, 1);
    chk("ovf_sticky", bus.ovf_sticky, 1);
    step();
    burst(1, 1, 1, 1);
    chk("clean_ovf", bus.out_ovf, 0);
    chk("clean_sticky", bus.ovf_sticky, 1);
    step();
    bus.out_ready = 1'b0;
    burst(3, 5, 7, 9);
    bus.in_valid = 1'b1; bus.in_data = 4'd2;
    repeat (5) step();
    chk("stall_data", bus.out_data, 24);
    chk("stall_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    step();
    chk("after_deliver_data", bus.out_data, 0);
    burst(2, 2, 2, 2);
    chk("post_stall_data", bus.out_data, 8);
    step();
    send(4); send(4);
    clear = 1'b1;
    #1 chk("clear_ready", bus.in_ready, 0);
    step();
    clear = 1'b0; bus.in_valid = 1'b0;
    chk("clear_data", bus.out_data, 0);
    chk("clear_sticky", bus.ovf_sticky, 0);
    burst(4, 4, 4, 4);
    chk("after_clear_data", bus.out_data, 16);
    step();
    bus.out_ready = 1'b0;
    burst(15, 15, 15, 15);
    chk("ovf2_data", bus.out_data, SAT ? 31 : 28);
    bus.out_ready = 1'b1; clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_dlv_valid", bus.out_valid, 0);
    chk("clr_dlv_sticky", bus.ovf_sticky, 0);
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = $urandom_range(0, 3) != 0;
      bus.in_data   = DATA_W'($urandom);
      bus.out_ready = $urandom_range(0, 2) != 0;
      clear         = $urandom_range(0, 29) == 0;
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else step();
    end
    bus.in_valid = 1'b0; clear = 1'b0;
    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
